// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------------------------------------------------------------------
// Round-robin, burst-based arbiter that shares the write side of an async
// FIFO (wclk domain) among NREQ valid/ready producers.  The winner of an
// arbitration keeps the port for up to MAX_BURST beats, or until its valid
// drops.  Then the port returns to IDLE for one cycle and rotates.
// wfull stalls the burst without ending it, so a full FIFO never sees winc.
//
// Parameters
//   DSIZE      data width (matches FIFO DSIZE)
//   NREQ       number of requesters, 2..8
//   MAX_BURST  max beats per grant, 1..16
//
// Ports
//   clk        write-side clock, all state on rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester beat available
//   req_data   beat of requester i at [i*DSIZE +: DSIZE]
//   req_ready  per-requester beat accepted this cycle
//   wfull      FIFO full flag
//   winc       FIFO write enable
//   wdata      FIFO write data (driven 0 while idle)
//   grant      registered one-hot owner, 0 when idle
//   busy       high while a burst is in progress
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [NREQ-1:0]         grant,
    output logic                    busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0]   LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IDXW-1:0] LAST_REQ  = IDXW'(NREQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic [IDXW-1:0]  last_q,  last_d;
    logic [CW-1:0]    count_q, count_d;

    logic [DSIZE-1:0] data_arr [NREQ];
    logic [IDXW-1:0]  sel;
    logic             sel_found;
    logic             owner_valid;

    // Unpack the flat data bus so the owner's beat can be picked by index.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    // Round-robin search: first valid requester strictly after the last
    // winner, wrapping modulo NREQ.  The last winner itself is tried last.
    always_comb begin : rr_search
        int              idx;
        logic [IDXW-1:0] cand;
        idx       = 0;
        cand      = '0;
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDXW'(idx);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    // Output path: the transfer qualifier is combinational so a beat moves
    // in the same cycle its valid is seen, while the grant stays registered.
    assign busy        = (state_q == BURST);
    assign owner_valid = req_valid[owner_q];
    assign winc        = busy & owner_valid & ~wfull;
    assign req_ready   = winc ? grant_q : '0;
    assign wdata       = busy ? data_arr[owner_q] : '0;
    assign grant       = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d      = BURST;
                    owner_d      = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    count_d      = '0;
                end
            end
            BURST: begin
                // A dropped valid ends the burst; a full FIFO only stalls it.
                if (!owner_valid || (winc && count_q == LAST_BEAT)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                    count_d = '0;
                end else if (winc) begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_REQ;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter.  A driver issues one cycle of stimulus at a
// time and pushes the expected outputs of that cycle into a scoreboard queue;
// a monitor on the falling edge pops and compares, and logs every FIFO write.
// Directed phases check the write log against fixed expected sequences; a
// randomized phase checks every cycle against the reference model.
module tb_fifo_wr_arbiter;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 2;
    localparam int MAX_BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DSIZE     (DSIZE),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct {
        int               cyc;
        logic             busy;
        logic [NREQ-1:0]  grant;
        logic             winc;
        logic [NREQ-1:0]  ready;
        logic [DSIZE-1:0] wdata;
        logic             chk_data;
    } exp_t;

    typedef struct {
        int               cyc;
        int               id;
        logic [DSIZE-1:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  log_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: owner (-1 when idle), beats taken, last winner.
    int m_owner;
    int m_beats;
    int m_last;

    // Producers: a pending beat is held until accepted.
    logic             pend [NREQ];
    logic [DSIZE-1:0] pdat [NREQ];
    logic [DSIZE-1:0] base [NREQ];
    int               seq  [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, want);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = NREQ - 1;
    endtask

    // Drive one cycle, record its expectation, advance the model, then move
    // to just after the next rising edge.
    task automatic cycle(input logic [NREQ-1:0] want, input logic full, input logic r);
        exp_t e;
        int   idx;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && want[i]) begin
                pend[i] = 1'b1;
                pdat[i] = base[i] + DSIZE'(seq[i]);
                seq[i]++;
            end
            req_valid[i]                 = pend[i];
            req_data[i*DSIZE +: DSIZE]   = pdat[i];
        end
        wfull = full;
        rst   = r;

        e.cyc      = cyc;
        e.busy     = (m_owner >= 0);
        e.grant    = '0;
        e.winc     = 1'b0;
        e.wdata    = '0;
        if (e.busy) begin
            e.grant[m_owner] = 1'b1;
            e.winc           = pend[m_owner] && !full;
            e.wdata          = pdat[m_owner];
        end
        e.ready    = e.winc ? e.grant : '0;
        e.chk_data = e.winc || !e.busy;
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (m_owner < 0 && req_valid[idx]) begin
                    m_owner = idx;
                    m_beats = 0;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (e.winc) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        if (e.winc) pend[m_owner >= 0 ? m_owner : m_last] = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            seq[i]  = 0;
        end
        cycle('0, 1'b0, 1'b1);
        log_q.delete();
    endtask

    // Monitor: compare each cycle's outputs and log the writes.
    initial begin : monitor
        exp_t e;
        int   id;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",     32'(grant),     32'(e.grant));
                chk("busy",      32'(busy),      32'(e.busy));
                chk("winc",      32'(winc),      32'(e.winc));
                chk("req_ready", 32'(req_ready), 32'(e.ready));
                if (e.chk_data) chk("wdata", 32'(wdata), 32'(e.wdata));
                if (winc === 1'b1) begin
                    id = -1;
                    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) id = i;
                    log_q.push_back('{cyc: e.cyc, id: id, data: wdata});
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int s;
        logic [NREQ-1:0] w;
        rst       = 1'b1;
        wfull     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pdat[i] = '0;
            base[i] = '0;
            seq[i]  = 0;
        end
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with all valid high, then first grant after release.
        cycle('1, 1'b0, 1'b1);
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_winc",  32'(winc),  32'h0);
        chk("reset_ready", 32'(req_ready), 32'h0);
        cycle('1, 1'b0, 1'b0);
        chk("grant_after_reset", 32'(grant), 32'h1);

        // Single requester, six beats: 4-beat burst, bubble, 2-beat burst.
        do_reset();
        base[0] = 8'h10;
        s = cyc;
        for (int c = 0; c < 12; c++) cycle({1'b0, (seq[0] < 6)}, 1'b0, 1'b0);
        chk("single_count", 32'(log_q.size()), 32'd6);
        if (log_q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("single_data", 32'(log_q[k].data), 32'h10 + 32'(k));
                chk("single_id",   32'(log_q[k].id),   32'd0);
            end
            chk("single_latency", 32'(log_q[0].cyc - s), 32'd1);
            chk("single_bubble",  32'(log_q[4].cyc - log_q[3].cyc), 32'd2);
        end

        // Contention: strict alternation of 4-beat bursts.
        do_reset();
        base[0] = 8'h20;
        base[1] = 8'h30;
        for (int c = 0; c < 15; c++) cycle('1, 1'b0, 1'b0);
        chk("contend_count", 32'(log_q.size()), 32'd12);
        if (log_q.size() == 12) begin
            for (int k = 0; k < 12; k++) chk("contend_id", 32'(log_q[k].id), 32'((k / 4) % 2));
            chk("contend_req1_data", 32'(log_q[4].data), 32'h30);
            chk("contend_req0_resume", 32'(log_q[8].data), 32'h24);
        end

        // Full stall after two beats: burst completes with two more beats.
        do_reset();
        base[0] = 8'h40;
        for (int c = 1; c <= 9; c++) begin
            cycle(2'b01, (c >= 4 && c <= 6), 1'b0);
            if (c == 4) begin
                chk("stall_winc",  32'(winc),      32'h0);
                chk("stall_ready", 32'(req_ready), 32'h0);
                chk("stall_grant", 32'(grant),     32'h1);
            end
        end
        chk("stall_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk("stall_gap",  32'(log_q[2].cyc - log_q[1].cyc), 32'd4);
            chk("stall_last", 32'(log_q[3].data), 32'h43);
        end

        // Valid drop by req1 after one beat: req0 wins next.
        do_reset();
        base[0] = 8'h60;
        base[1] = 8'h50;
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        chk("drop_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("drop_first_id",  32'(log_q[0].id), 32'd1);
            chk("drop_next_id",   32'(log_q[1].id), 32'd0);
            chk("drop_next_data", 32'(log_q[1].data), 32'h60);
            chk("drop_gap", 32'(log_q[1].cyc - log_q[0].cyc), 32'd3);
        end

        // Reset in the middle of a req1 burst: priority restarts at req0.
        do_reset();
        base[0] = 8'h80;
        base[1] = 8'h70;
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b1);
        chk("midrst_winc", 32'(winc), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        chk("midrst_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk("midrst_id",   32'(log_q[3].id),   32'd0);
            chk("midrst_data", 32'(log_q[3].data), 32'h80);
            chk("midrst_gap",  32'(log_q[3].cyc - log_q[2].cyc), 32'd2);
        end

        // Randomized traffic, back-pressure and occasional reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) base[i] = DSIZE'($urandom);
        for (int n = 0; n < 3000; n++) begin
            w = NREQ'($urandom);
            cycle(w, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
        end
        chk("random_writes_seen", 32'(log_q.size() > 300), 32'd1);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
